// File: rtl/shift_operand_stage.sv
// Operand-prep stage for the barrel shifter: decodes shift form/amount and
// registers it behind a two-entry (main + skid) buffer with a flopped inReady.
module shift_operand_stage #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [31:0]      rm,
  input  logic [31:0]      rs,
  input  logic [4:0]       imm5,
  input  logic [1:0]       shType,
  input  logic             regShift,
  input  logic             immRot,
  input  logic [7:0]       imm8,
  input  logic [3:0]       rot4,
  input  logic [TAG_W-1:0] inTag,
  output logic [TAG_W-1:0] outTag,
  output logic             outValid,
  input  logic             outReady,
  output logic [31:0]      shIn,
  output logic [1:0]       shOp,
  output logic [31:0]      shAmt,
  output logic             rrx
);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             rrx;
    logic [31:0]      amt;
    logic [1:0]       op;
    logic [31:0]      opnd;
  } beat_t;

  beat_t in_beat, main_q, skid_q, main_d, skid_d;
  logic  main_vld, skid_vld, main_vld_d, skid_vld_d, rdy_q;
  logic  acc, drain;

  // only the low byte of rs ever reaches the shifter
  logic  unused_rs_hi;
  assign unused_rs_hi = ^rs[31:8];

  always_comb begin
    in_beat      = '0;
    in_beat.tag  = inTag;
    in_beat.opnd = rm;
    in_beat.op   = shType;
    if (immRot) begin
      in_beat.opnd = {24'b0, imm8};
      in_beat.op   = 2'b11;
      in_beat.amt  = {27'b0, rot4, 1'b0};
    end else if (regShift) begin
      in_beat.amt = (shType == 2'b11) ? {27'b0, rs[4:0]} : {24'b0, rs[7:0]};
    end else begin
      case (shType)
        2'b00:   in_beat.amt = {27'b0, imm5};
        2'b01,
        2'b10:   in_beat.amt = (imm5 == 5'd0) ? 32'd32 : {27'b0, imm5};
        default: begin
          if (imm5 == 5'd0) begin
            // RRX: one-bit right shift, carry injected downstream
            in_beat.op  = 2'b01;
            in_beat.amt = 32'd1;
            in_beat.rrx = 1'b1;
          end else begin
            in_beat.amt = {27'b0, imm5};
          end
        end
      endcase
    end
  end

  assign acc   = inValid && rdy_q;
  assign drain = main_vld && outReady;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld;
    skid_vld_d = skid_vld;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (drain || !main_vld) begin
      if (skid_vld) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_d     = in_beat;
        skid_vld_d = acc;
      end else begin
        main_d     = in_beat;
        main_vld_d = acc;
      end
    end else if (acc) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      if (main_vld_d && (drain || !main_vld)) main_q <= main_d;
      if (skid_vld_d) skid_q <= skid_d;
      main_vld <= main_vld_d;
      skid_vld <= skid_vld_d;
      rdy_q    <= !skid_vld_d;
    end
  end

  assign inReady  = rdy_q;
  assign outValid = main_vld;
  assign outTag   = main_q.tag;
  assign shIn     = main_q.opnd;
  assign shOp     = main_q.op;
  assign shAmt    = main_q.amt;
  assign rrx      = main_q.rrx;

endmodule

// File: tb/tb_shift_operand_stage.sv
// Scoreboard bench: accepted beats push expected results, a negedge monitor
// pops and compares every beat that transfers downstream.
module tb_shift_operand_stage;
  logic        clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic        inValid = 1'b0, inReady, outValid, outReady = 1'b1;
  logic [31:0] rm = '0, rs = '0, shIn, shAmt;
  logic [4:0]  imm5 = '0;
  logic [1:0]  shType = '0, shOp;
  logic        regShift = 1'b0, immRot = 1'b0, rrx;
  logic [7:0]  imm8 = '0;
  logic [3:0]  rot4 = '0, inTag = '0, outTag;

  typedef struct {
    logic [31:0] shIn;
    logic [1:0]  op;
    logic [31:0] amt;
    logic        rrx;
    logic [3:0]  tag;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  shift_operand_stage #(.TAG_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .inValid(inValid), .inReady(inReady),
    .rm(rm), .rs(rs), .imm5(imm5), .shType(shType), .regShift(regShift), .immRot(immRot),
    .imm8(imm8), .rot4(rot4), .inTag(inTag), .outTag(outTag), .outValid(outValid),
    .outReady(outReady), .shIn(shIn), .shOp(shOp), .shAmt(shAmt), .rrx(rrx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // monitor: one comparison per beat that transfers on the coming edge
  always @(negedge clk) begin
    if (reset_n && outValid && outReady) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL beat: got unexpected tag %0d, want no beat", outTag);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (shIn !== e.shIn || shOp !== e.op || shAmt !== e.amt || rrx !== e.rrx || outTag !== e.tag) begin
          n_bad++;
          $display("FAIL beat: got tag%0d in=%h op=%b amt=%0d rrx=%b want tag%0d in=%h op=%b amt=%0d rrx=%b",
                   outTag, shIn, shOp, shAmt, rrx, e.tag, e.shIn, e.op, e.amt, e.rrx);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] tg, input logic ir, input logic rg, input logic [1:0] st,
                       input logic [31:0] vrm, input logic [31:0] vrs, input logic [4:0] i5,
                       input logic [7:0] i8, input logic [3:0] r4);
    inTag = tg; immRot = ir; regShift = rg; shType = st;
    rm = vrm; rs = vrs; imm5 = i5; imm8 = i8; rot4 = r4;
    inValid = 1'b1;
  endtask

  task automatic wait_acc(input logic [31:0] ein, input logic [1:0] eop, input logic [31:0] eamt,
                          input logic err);
    exp_t e;
    int   n = 0;
    logic r;
    do begin
      @(negedge clk); r = inReady;
      @(posedge clk); n++;
    end while (!r && n < 50);
    if (!r) begin
      n_cmp++; n_bad++;
      $display("FAIL accept: got no accept of tag %0d, want accept within 50 cycles", inTag);
    end else begin
      e.shIn = ein; e.op = eop; e.amt = eamt; e.rrx = err; e.tag = inTag;
      sb.push_back(e);
    end
    #1 inValid = 1'b0;
  endtask

  task automatic send(input logic [3:0] tg, input logic ir, input logic rg, input logic [1:0] st,
                      input logic [31:0] vrm, input logic [31:0] vrs, input logic [4:0] i5,
                      input logic [7:0] i8, input logic [3:0] r4,
                      input logic [31:0] ein, input logic [1:0] eop, input logic [31:0] eamt,
                      input logic err);
    drive(tg, ir, rg, st, vrm, vrs, i5, i8, r4);
    wait_acc(ein, eop, eamt, err);
  endtask

  initial begin
    #3;
    chk("rst_outValid", {31'b0, outValid}, 32'd0);
    chk("rst_inReady", {31'b0, inReady}, 32'd0);
    chk("rst_shIn", shIn, 32'd0);
    chk("rst_shAmt", shAmt, 32'd0);
    chk("rst_misc", {27'b0, outTag, rrx}, 32'd0);
    #9 reset_n = 1'b1;
    @(negedge clk);
    chk("rel_inReady", {31'b0, inReady}, 32'd1);

    // directed decode vectors, streaming with outReady=1
    @(posedge clk); #1;
    send(4'd1, 1, 0, 2'b00, 32'h0, 32'h0, 5'd0, 8'hFF, 4'd4, 32'h000000FF, 2'b11, 32'd8, 0);
    @(negedge clk);
    chk("latency1", {31'b0, outValid}, 32'd1);
    @(posedge clk); #1;
    send(4'd2, 0, 0, 2'b01, 32'h80000000, 32'h0, 5'd0, 8'h0, 4'd0, 32'h80000000, 2'b01, 32'd32, 0);
    send(4'd3, 0, 0, 2'b11, 32'h12345678, 32'h0, 5'd0, 8'h0, 4'd0, 32'h12345678, 2'b01, 32'd1, 1);
    send(4'd4, 0, 1, 2'b11, 32'hCAFEF00D, 32'h125, 5'd9, 8'h0, 4'd0, 32'hCAFEF00D, 2'b11, 32'd5, 0);
    send(4'd5, 0, 1, 2'b00, 32'hCAFEF00D, 32'h125, 5'd9, 8'h0, 4'd0, 32'hCAFEF00D, 2'b00, 32'h25, 0);
    send(4'd6, 0, 0, 2'b10, 32'hF0000000, 32'h0, 5'd0, 8'h0, 4'd0, 32'hF0000000, 2'b10, 32'd32, 0);
    send(4'd7, 0, 0, 2'b00, 32'h00000011, 32'h0, 5'd0, 8'h0, 4'd0, 32'h00000011, 2'b00, 32'd0, 0);
    send(4'd8, 0, 0, 2'b11, 32'h00000022, 32'h0, 5'd7, 8'h0, 4'd0, 32'h00000022, 2'b11, 32'd7, 0);
    send(4'd9, 0, 1, 2'b10, 32'h00000033, 32'hFFFFFF80, 5'd0, 8'h0, 4'd0, 32'h00000033, 2'b10, 32'h80, 0);
    send(4'd10, 1, 1, 2'b00, 32'h44, 32'hFF, 5'd3, 8'h3C, 4'd15, 32'h0000003C, 2'b11, 32'd30, 0);
    repeat (3) @(posedge clk);
    #1;

    // backpressure: two accepted, third stalls
    outReady = 1'b0;
    send(4'd1, 0, 0, 2'b00, 32'hA1, 32'h0, 5'd1, 8'h0, 4'd0, 32'hA1, 2'b00, 32'd1, 0);
    send(4'd2, 0, 0, 2'b00, 32'hA2, 32'h0, 5'd2, 8'h0, 4'd0, 32'hA2, 2'b00, 32'd2, 0);
    drive(4'd3, 0, 0, 2'b00, 32'hA3, 32'h0, 5'd3, 8'h0, 4'd0);
    repeat (2) begin
      @(negedge clk);
      chk("bp_inReady", {31'b0, inReady}, 32'd0);
      chk("bp_outTag", {28'b0, outTag}, 32'd1);
      chk("bp_shIn", shIn, 32'hA1);
    end
    @(posedge clk); #1;
    outReady = 1'b1;
    wait_acc(32'hA3, 2'b00, 32'd3, 0);
    repeat (4) @(posedge clk);
    #1;

    // flush with both entries full and a concurrent offer
    outReady = 1'b0;
    send(4'd4, 0, 0, 2'b00, 32'hB4, 32'h0, 5'd4, 8'h0, 4'd0, 32'hB4, 2'b00, 32'd4, 0);
    send(4'd5, 0, 0, 2'b00, 32'hB5, 32'h0, 5'd5, 8'h0, 4'd0, 32'hB5, 2'b00, 32'd5, 0);
    drive(4'd6, 0, 0, 2'b00, 32'hB6, 32'h0, 5'd6, 8'h0, 4'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; inValid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_outValid", {31'b0, outValid}, 32'd0);
    chk("flush_inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk); #1;
    outReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(4'd7, 0, 0, 2'b01, 32'hC7, 32'h0, 5'd3, 8'h0, 4'd0, 32'hC7, 2'b01, 32'd3, 0);
    repeat (3) @(posedge clk);
    #1;

    // asynchronous reset while a beat is held
    outReady = 1'b0;
    send(4'd8, 0, 0, 2'b00, 32'hD8, 32'h0, 5'd8, 8'h0, 4'd0, 32'hD8, 2'b00, 32'd8, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_outValid", {31'b0, outValid}, 32'd0);
    chk("arst_outTag", {28'b0, outTag}, 32'd0);
    sb.delete();
    @(negedge clk);
    chk("arst_inReady", {31'b0, inReady}, 32'd0);
    #1 reset_n = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    chk("rel2_inReady", {31'b0, inReady}, 32'd1);
    @(posedge clk); #1;
    send(4'd9, 0, 0, 2'b10, 32'hE9, 32'h0, 5'd9, 8'h0, 4'd0, 32'hE9, 2'b10, 32'd9, 0);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
